// File: rtl/cfg_pkg.sv
// Shared definitions for the front-end configuration serializer:
// state encoding, frame layout and fixed timing constants.
package cfg_pkg;

  localparam int GA1_W        = 2;
  localparam int GA2_W        = 3;
  localparam int FRAME_BITS   = GA1_W + GA2_W;
  localparam int GUARD_CYCLES = 2;
  localparam int DIV_W        = 4;   // holds the largest legal CLK_DIV (15)

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_RST_GUARD  = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } cfg_state_t;

  // Width of a counter that must hold the largest of three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cfg_bit_timer.sv
// Serial clock phase generator: while enabled, produces a 50% duty sclk
// with a half-period of CLK_DIV cycles, starting in the low phase.
module cfg_bit_timer
  import cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_fall_tick
);

  localparam logic [DIV_W-1:0] C_HALF_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_tick;

  assign w_tick      = i_en && (r_cnt == C_HALF_LAST);
  assign o_fall_tick = w_tick && r_phase;
  assign o_sclk      = r_phase;

  // Half-period counter; phase toggles at the end of every half-period and
  // is forced low whenever the timer is disabled so sclk idles at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_serial_tx.sv
// Configuration frame transmitter: resets the front end, shifts the two
// gain codes out LSB first (A1 then A2), then waits for the ready flag.
module cfg_serial_tx
  import cfg_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int RST_CYCLES    = 4,
  parameter int READY_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_resetAll,
  input  logic             i_start,
  input  logic [GA1_W-1:0] i_gainA1,
  input  logic [GA2_W-1:0] i_gainA2,
  input  logic             i_ready,
  output logic             o_resetbAll,
  output logic             o_sclk,
  output logic             o_sdin,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int CNT_W = cnt_width(RST_CYCLES, GUARD_CYCLES, READY_TIMEOUT);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] C_RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST  = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  cfg_state_t            r_state;
  cfg_state_t            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bitcnt;
  logic [FRAME_BITS-1:0] r_shreg;
  logic                  r_resetb;
  logic                  w_shift_en;
  logic                  w_sclk;
  logic                  w_fall_tick;
  logic                  w_accept;
  logic                  w_counting;

  cfg_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .i_clk       (i_clk),
    .i_rst       (i_resetAll),
    .i_en        (w_shift_en),
    .o_sclk      (w_sclk),
    .o_fall_tick (w_fall_tick)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_counting  = (r_state == ST_RST_ASSERT) || (r_state == ST_RST_GUARD) ||
                       (r_state == ST_WAIT_READY);
  assign o_sclk      = w_sclk;
  assign o_resetbAll = r_resetb;

  // State register.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next-state and per-state outputs; ready is only looked at while waiting,
  // and a ready seen on the final wait cycle still counts as success.
  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_timeout  = 1'b0;
    w_shift_en = 1'b0;
    o_sdin     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_RST_ASSERT;
      end
      ST_RST_ASSERT: begin
        o_busy = 1'b1;
        if (r_cnt == C_RST_LAST) w_next = ST_RST_GUARD;
      end
      ST_RST_GUARD: begin
        o_busy = 1'b1;
        if (r_cnt == C_GUARD_LAST) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy     = 1'b1;
        w_shift_en = 1'b1;
        o_sdin     = r_shreg[0];
        if (w_fall_tick && (r_bitcnt == C_BIT_LAST)) w_next = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        o_busy = 1'b1;
        if (i_ready)                   w_next = ST_DONE;
        else if (r_cnt == C_WAIT_LAST) w_next = ST_ERROR;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERROR: begin
        o_timeout = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state cycle counter: restarts at 0 on every state change and only
  // runs in the timed states, each of which exits before the counter's max.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll)              r_cnt <= '0;
    else if (w_next != r_state)  r_cnt <= '0;
    else if (w_counting)         r_cnt <= r_cnt + 1'b1;
  end

  // Bit counter advances on each sclk fall, i.e. after a bit has been sampled.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll)               r_bitcnt <= '0;
    else if (r_state != ST_SHIFT) r_bitcnt <= '0;
    else if (w_fall_tick)         r_bitcnt <= r_bitcnt + 1'b1;
  end

  // Frame shift register: loaded only when a request is accepted, shifted
  // right on each sclk fall so the next bit is set up during the low phase.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll)
      r_shreg <= '0;
    else if (w_accept)
      r_shreg <= {i_gainA2, i_gainA1};
    else if ((r_state == ST_SHIFT) && w_fall_tick)
      r_shreg <= {1'b0, r_shreg[FRAME_BITS-1:1]};
  end

  // Front-end reset: driven low on accept, released when the assert window
  // ends, and otherwise held so it stays high between frames.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll)
      r_resetb <= 1'b0;
    else if (w_accept)
      r_resetb <= 1'b0;
    else if ((r_state == ST_RST_ASSERT) && (w_next == ST_RST_GUARD))
      r_resetb <= 1'b1;
  end

endmodule

// File: tb/tb_cfg_serial_tx.sv
module tb_cfg_serial_tx;

  localparam int CLK_DIV       = 2;
  localparam int RST_CYCLES    = 4;
  localparam int READY_TIMEOUT = 64;
  // Relative cycle numbers (cycle 1 = first cycle after the accepting edge).
  localparam int SH0 = RST_CYCLES + 3;          // first SHIFT cycle
  localparam int W0  = SH0 + 10 * CLK_DIV;      // first WAIT_READY cycle

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] ga1 = '0;
  logic [2:0] ga2 = '0;
  logic       i_ready = 1'b0;
  logic       resetb, sclk, sdin, busy, done, tmo;

  always #5 clk = ~clk;

  cfg_serial_tx #(
    .CLK_DIV       (CLK_DIV),
    .RST_CYCLES    (RST_CYCLES),
    .READY_TIMEOUT (READY_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_resetAll  (rst),
    .i_start     (i_start),
    .i_gainA1    (ga1),
    .i_gainA2    (ga2),
    .i_ready     (i_ready),
    .o_resetbAll (resetb),
    .o_sclk      (sclk),
    .o_sdin      (sdin),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (tmo)
  );

  typedef struct {
    int         k;      // cyc value seen in relative cycle 1
    logic [4:0] bits;   // {gainA2, gainA1}
    int         j;      // wait-cycle index where ready first rises, -1 = never
  } frame_t;

  frame_t sb[$];
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  bit     in_rst = 1'b1;
  bit     rb_idle = 1'b0;

  // Front-end model state.
  int         fe_j = -1;
  bit         fe_wait = 1'b0;
  int         fe_wcnt = 0;
  int         fe_rises = 0;
  logic [4:0] fe_bits = '0;
  logic       fe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit ok_frame(frame_t e);
    return (e.j >= 0) && (e.j <= READY_TIMEOUT - 1);
  endfunction

  function automatic int frame_end(frame_t e);
    return W0 + (ok_frame(e) ? e.j + 1 : READY_TIMEOUT);
  endfunction

  // Expected {resetb, sclk, sdin, busy, done, timeout} in relative cycle rel.
  function automatic logic [5:0] exp_vec(frame_t e, int rel);
    int   fin, off;
    logic rb, sc, sd, bz, dn, to;
    fin = frame_end(e);
    rb  = (rel > RST_CYCLES);
    sc  = 1'b0;
    sd  = 1'b0;
    if (rel >= SH0 && rel < W0) begin
      off = rel - SH0;
      sc  = ((off / CLK_DIV) % 2) == 1;
      sd  = e.bits[off / (2 * CLK_DIV)];
    end
    bz = rel < fin;
    dn = (rel == fin) && ok_frame(e);
    to = (rel == fin) && !ok_frame(e);
    return {rb, sc, sd, bz, dn, to};
  endfunction

  // Behavioural front end: captures sdin on sclk rises while out of reset,
  // raises ready j cycles after the last fall, and drives noise otherwise.
  always @(negedge clk) begin
    if (resetb !== 1'b1) begin
      fe_wait  = 1'b0;
      fe_wcnt  = 0;
      fe_rises = 0;
      fe_bits  = '0;
    end else begin
      if (sclk && !fe_prev && fe_rises < 5) begin
        fe_bits[fe_rises] = sdin;
        fe_rises++;
      end
      if (!sclk && fe_prev && fe_rises == 5 && !fe_wait) begin
        fe_wait = 1'b1;
        fe_wcnt = 0;
      end else if (fe_wait) begin
        fe_wcnt++;
      end
    end
    fe_prev = sclk;
    i_ready = fe_wait ? (fe_j >= 0 && fe_wcnt >= fe_j) : 1'($urandom_range(0, 1));
  end

  // Monitor: compares every cycle against the head frame's expected waveform
  // and retires the frame when the DUT signals completion (or is overdue).
  always @(negedge clk) begin
    logic [5:0] act;
    int         rel;
    if (!in_rst) begin
      act = {resetb, sclk, sdin, busy, done, tmo};
      if (sb.size() == 0 || (cyc - sb[0].k + 1) < 1) begin
        check("idle_outputs", 32'(act), 32'({rb_idle, 5'b0}));
      end else begin
        rel = cyc - sb[0].k + 1;
        check($sformatf("frame_rel%0d", rel), 32'(act), 32'(exp_vec(sb[0], rel)));
        if (done || tmo || rel >= frame_end(sb[0])) begin
          check("fe_rises", 32'(fe_rises), 32'd5);
          check("fe_bits", 32'(fe_bits), 32'(sb[0].bits));
          void'(sb.pop_front());
          rb_idle = 1'b1;
        end
      end
    end
  end

  // mode 0: plain frame, 1: extra start during SHIFT, 2: reset mid-frame.
  task automatic run_frame(input logic [1:0] a1, input logic [2:0] a2, input int j, input int mode);
    frame_t e;
    while (sb.size() != 0) @(negedge clk);
    @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    fe_j    = j;
    ga1     = a1;
    ga2     = a2;
    i_start = 1'b1;
    e.k     = cyc + 1;
    e.bits  = {a2, a1};
    e.j     = (mode == 2) ? -1 : j;
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    ga1     = 2'($urandom);
    ga2     = 3'($urandom);
    if (mode == 1) begin
      repeat (SH0 + 2) @(negedge clk);
      ga1     = ~a1;
      ga2     = ~a2;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end else if (mode == 2) begin
      repeat (SH0 + 2 * 2 * CLK_DIV - 1) @(negedge clk);   // just past 2nd rise
      @(posedge clk);
      #1;
      in_rst = 1'b1;
      rst    = 1'b1;
      #1;
      check("rst_midframe", 32'({resetb, sclk, sdin, busy, done, tmo}), 32'd0);
      sb.delete();
      rb_idle = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      in_rst = 1'b0;
    end
  endtask

  function automatic int pick_j();
    case ($urandom_range(0, 6))
      0:       return 0;
      1:       return 22;
      2:       return READY_TIMEOUT - 2;
      3:       return READY_TIMEOUT - 1;
      4:       return READY_TIMEOUT;
      5:       return -1;
      default: return int'($urandom_range(0, READY_TIMEOUT + 8));
    endcase
  endfunction

  initial begin
    #1;
    check("reset_state", 32'({resetb, sclk, sdin, busy, done, tmo}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_rst = 1'b0;

    run_frame(2'b01, 3'b110, 22, 0);                 // reference frame, ready late
    run_frame(2'b01, 3'b110, -1, 0);                 // ready never comes
    run_frame(2'b10, 3'b101, READY_TIMEOUT - 1, 0);  // ready on the timeout cycle
    run_frame(2'b11, 3'b001, READY_TIMEOUT, 0);      // ready one cycle too late
    run_frame(2'b00, 3'b111, 0, 0);                  // ready immediately
    run_frame(2'b10, 3'b011, 5, 2);                  // reset after 2nd rise
    run_frame(2'b01, 3'b010, 10, 0);                 // full frame after reset
    run_frame(2'b11, 3'b100, 12, 1);                 // ignored restart in SHIFT
    for (int n = 0; n < 24; n++)
      run_frame(2'($urandom), 3'($urandom), pick_j(), int'($urandom_range(0, 4) == 0));

    while (sb.size() != 0) @(negedge clk);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (40000) @(posedge clk);
    fails++;
    $display("FAIL watchdog: run did not finish, got cyc %0d expected < 40000", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_serial_tx.md
CFG_SERIAL_TX -- requirements
Module: cfg_serial_tx

Interface
REQ-001 Parameter CLK_DIV, default 2: sclk half-period in i_clk cycles, legal range 1..15.
REQ-002 Parameter RST_CYCLES, default 4: i_clk cycles that o_resetbAll is held low per frame.
REQ-003 Parameter READY_TIMEOUT, default 64: i_clk cycles to wait for i_ready after the last bit.
REQ-004 i_clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-005 i_resetAll  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  one-cycle request to send one configuration frame.
REQ-007 i_gainA1  input  2  first-stage gain code.
REQ-008 i_gainA2  input  3  second-stage gain code.
REQ-009 i_ready  input  1  ready flag returned by the configured front end.
REQ-010 o_resetbAll  output  1  active-low reset to the front end.
REQ-011 o_sclk  output  1  serial clock; the front end samples on its rising edge.
REQ-012 o_sdin  output  1  serial data.
REQ-013 o_busy  output  1  high while a frame is in progress.
REQ-014 o_done  output  1  one-cycle pulse on successful completion.
REQ-015 o_timeout  output  1  one-cycle pulse when i_ready is not seen in time.

Function
REQ-016 FSM states: IDLE, RST_ASSERT, RST_GUARD, SHIFT, WAIT_READY, DONE, ERROR.
REQ-017 IDLE: when i_start=1 at edge k, latch {i_gainA2, i_gainA1} into a 5-bit shift register, go to RST_ASSERT, and set o_busy=1 from k+1.
REQ-018 i_start is ignored in every state other than IDLE; gain inputs are sampled only at edge k.
REQ-019 RST_ASSERT: o_resetbAll=0 for cycles k+1..k+RST_CYCLES; o_resetbAll rises at k+RST_CYCLES+1.
REQ-020 RST_GUARD: 2 cycles with o_sclk=0 and o_resetbAll=1; o_sclk shall never be high when o_resetbAll rises.
REQ-021 Bit order: gainA1[0], gainA1[1], gainA2[0], gainA2[1], gainA2[2] (LSB first, A1 first).
REQ-022 SHIFT, per bit: o_sdin updates while o_sclk=0, o_sclk stays low for CLK_DIV cycles then high for CLK_DIV cycles; o_sdin is stable throughout each high phase.
REQ-023 SHIFT lasts exactly 10*CLK_DIV cycles, emits exactly 5 rising edges, and ends with o_sclk=0 and o_sdin=0.
REQ-024 WAIT_READY: i_ready is sampled only in this state and a cycle counter starts at 0. If i_ready=1, go to DONE. If the count reaches READY_TIMEOUT-1 without i_ready, go to ERROR.
REQ-025 If i_ready=1 on the timeout cycle, i_ready wins and the FSM goes to DONE.
REQ-026 DONE: o_done=1 for one cycle, then IDLE. ERROR: o_timeout=1 for one cycle, then IDLE. o_busy=0 in both states.
REQ-027 o_resetbAll keeps its last value (1) in IDLE after a frame; it returns to 0 only in RST_ASSERT or on reset.
REQ-028 Counters are sized for their parameter maxima and never wrap within a state.

Reset
REQ-029 While i_resetAll=1: state=IDLE, o_resetbAll=0, o_sclk=0, o_sdin=0, o_busy=0, o_done=0, o_timeout=0, and all counters and the shift register are cleared.
REQ-030 Reset mid-frame aborts the frame immediately with no o_done or o_timeout; the next i_start sends a complete frame.

Structure
REQ-031 Package cfg_pkg holds the state encoding, FRAME_BITS=5, the gain field widths, and the RST_GUARD length of 2.
REQ-032 One sub-module, cfg_bit_timer, generates the sclk phase ticks from CLK_DIV; the FSM and shift register stay in cfg_serial_tx.

Verification
REQ-033 CLK_DIV=2, gainA1=2'b01, gainA2=3'b110, i_start at edge 0 -> o_resetbAll low cycles 1-4, high at 5; sclk rises at 9,13,17,21,25 with sdin 1,0,0,1,1; a behavioural front-end model reports gainA1=01 and gainA2=110.
REQ-034 Front-end model asserts i_ready 22 cycles after the last sclk fall -> o_done pulses once, o_busy falls, and o_timeout stays 0.
REQ-035 i_ready tied 0 -> o_timeout pulses once 64 cycles after entering WAIT_READY, and o_done stays 0.
REQ-036 i_resetAll pulsed after the 2nd sclk rise -> all outputs at reset values the same cycle; a new i_start then yields 5 sclk rises.
REQ-037 i_start re-asserted during SHIFT with different gains -> ignored, and the frame bits are unchanged.
REQ-038 i_ready first high exactly on the timeout cycle -> o_done pulses and o_timeout does not.
